my_bullet_pool: RTL and testbench

- Upstream of the player-bullet address generators. Owns a fixed pool of player bullets: allocates a slot on a fire request, advances active bullets upward each move tick, and retires them at the screen top or on a hit.
- Publishes per-slot h/v offsets and an active mask. The address generators and the collision logic consume these outputs.
- Replaces the separate enable / edge-detect / per-bullet counter arrangement with one registered, single-clock pool.

---
 rtl/my_bullet_pool_pkg.sv | 9 +
 rtl/my_bullet_pool_if.sv | 23 ++
 rtl/my_bullet_pool_slot.sv | 29 ++
 rtl/my_bullet_pool.sv | 59 +++++
 tb/tb_my_bullet_pool.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/my_bullet_pool_pkg.sv
// my_bullet_pool_pkg: shared game screen constants and the 10-bit screen coordinate type
package my_bullet_pool_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BULLET_W = 16;
  localparam int V_PARK = 480;
  localparam int STEP = 2;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/my_bullet_pool_if.sv
// my_bullet_pool_if: pool bus; master drives tick/fire/plane position/hit, slave returns packed slot positions, active mask, fire_ack, pool_full
interface my_bullet_pool_if import my_bullet_pool_pkg::coord_t; #(
  parameter int N_SLOTS = 5
);
  logic tick;
  logic fire;
  coord_t h_my_plane;
  coord_t v_my_plane;
  logic [N_SLOTS-1:0] hit;
  logic [10*N_SLOTS-1:0] h_bullet;
  logic [10*N_SLOTS-1:0] v_bullet;
  logic [N_SLOTS-1:0] active;
  logic fire_ack;
  logic pool_full;
  modport master(
    output tick, fire, h_my_plane, v_my_plane, hit,
    input h_bullet, v_bullet, active, fire_ack, pool_full
  );
  modport slave(
    input tick, fire, h_my_plane, v_my_plane, hit,
    output h_bullet, v_bullet, active, fire_ack, pool_full
  );
endinterface

// File: rtl/my_bullet_pool_slot.sv
// my_bullet_pool_slot: one bullet slot (in clk, rst, spawn, spawn_h, spawn_v, tick, hit; out active, h, v); retire beats spawn beats move
module my_bullet_pool_slot import my_bullet_pool_pkg::coord_t; #(
  parameter int STEP = my_bullet_pool_pkg::STEP,
  parameter int V_PARK = my_bullet_pool_pkg::V_PARK
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   spawn,
  input  coord_t spawn_h,
  input  coord_t spawn_v,
  input  logic   tick,
  input  logic   hit,
  output logic   active,
  output coord_t h,
  output coord_t v
);
  always_ff @(posedge clk)
    if (rst || (active && (hit || (tick && v < coord_t'(STEP))))) begin
      active <= 1'b0;
      h <= '0;
      v <= coord_t'(V_PARK);
    end else if (spawn) begin
      active <= 1'b1;
      h <= spawn_h;
      v <= spawn_v;
    end else if (active && tick) begin
      v <= v - coord_t'(STEP);
    end
endmodule

// File: rtl/my_bullet_pool.sv
// my_bullet_pool: player bullet pool (clk, rst, bus slave: tick/fire/plane pos/hit in, h_bullet/v_bullet/active/fire_ack/pool_full out)
module my_bullet_pool import my_bullet_pool_pkg::coord_t; #(
  parameter int N_SLOTS = 5,
  parameter int STEP = my_bullet_pool_pkg::STEP,
  parameter int PLANE_W = 32,
  parameter int BULLET_W = my_bullet_pool_pkg::BULLET_W,
  parameter int COOLDOWN = 20,
  parameter int V_PARK = my_bullet_pool_pkg::V_PARK
) (
  input logic clk,
  input logic rst,
  my_bullet_pool_if.slave bus
);
  logic fire_prev;
  logic fire_rise;
  logic alloc;
  logic [15:0] cooldown;
  logic [N_SLOTS-1:0] free;
  logic [N_SLOTS-1:0] spawn;
  logic [N_SLOTS-1:0] act;
  logic [10*N_SLOTS-1:0] h_all;
  logic [10*N_SLOTS-1:0] v_all;
  coord_t spawn_h;
  coord_t spawn_v;
  assign fire_rise = bus.fire & ~fire_prev;
  assign free = ~act;
  assign alloc = fire_rise && cooldown == '0 && |free;
  assign spawn = alloc ? free & -free : '0;
  assign spawn_h = bus.h_my_plane + coord_t'(PLANE_W / 2 - BULLET_W / 2);
  assign spawn_v = bus.v_my_plane < coord_t'(BULLET_W) ? '0 : bus.v_my_plane - coord_t'(BULLET_W);
  always_ff @(posedge clk)
    if (rst) begin
      fire_prev <= 1'b0;
      cooldown <= '0;
      bus.fire_ack <= 1'b0;
    end else begin
      fire_prev <= bus.fire;
      bus.fire_ack <= alloc;
      cooldown <= alloc ? 16'(COOLDOWN) : (bus.tick && cooldown != '0) ? cooldown - 16'd1 : cooldown;
    end
  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    my_bullet_pool_slot #(.STEP(STEP), .V_PARK(V_PARK)) u_slot (
      .clk(clk),
      .rst(rst),
      .spawn(spawn[g]),
      .spawn_h(spawn_h),
      .spawn_v(spawn_v),
      .tick(bus.tick),
      .hit(bus.hit[g]),
      .active(act[g]),
      .h(h_all[10*g+:10]),
      .v(v_all[10*g+:10])
    );
  end
  assign bus.active = act;
  assign bus.h_bullet = h_all;
  assign bus.v_bullet = v_all;
  assign bus.pool_full = &act;
endmodule

// File: tb/tb_my_bullet_pool.sv
// tb_my_bullet_pool: table, directed and random checks of two pools (cooldown 20 and 0) against an array model
module tb_my_bullet_pool;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  my_bullet_pool_if #(.N_SLOTS(5)) b0();
  my_bullet_pool_if #(.N_SLOTS(5)) b1();
  assign b1.tick = b0.tick;
  assign b1.fire = b0.fire;
  assign b1.h_my_plane = b0.h_my_plane;
  assign b1.v_my_plane = b0.v_my_plane;
  assign b1.hit = b0.hit;
  my_bullet_pool #(.N_SLOTS(5), .COOLDOWN(20)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  my_bullet_pool #(.N_SLOTS(5), .COOLDOWN(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  bit ma[2][5];
  int mh[2][5];
  int mv[2][5];
  int mcd[2];
  bit mfp[2];
  bit mack[2];
  typedef struct {
    logic fire;
    logic [4:0] exp_act;
    logic exp_ack;
    logic exp_full;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask
  task automatic model_reset(int k);
    for (int i = 0; i < 5; i++) begin
      ma[k][i] = 0;
      mh[k][i] = 0;
      mv[k][i] = 480;
    end
    mcd[k] = 0;
    mfp[k] = 0;
    mack[k] = 0;
  endtask
  task automatic model_step(int k);
    int cdp;
    int fr;
    bit alloc;
    cdp = (k == 0) ? 20 : 0;
    fr = -1;
    for (int i = 4; i >= 0; i--) if (!ma[k][i]) fr = i;
    alloc = b0.fire && !mfp[k] && mcd[k] == 0 && fr >= 0;
    for (int i = 0; i < 5; i++)
      if (ma[k][i] && (b0.hit[i] || (b0.tick && mv[k][i] < 2))) begin
        ma[k][i] = 0;
        mh[k][i] = 0;
        mv[k][i] = 480;
      end else if (ma[k][i] && b0.tick) mv[k][i] -= 2;
    if (alloc) begin
      ma[k][fr] = 1;
      mh[k][fr] = (int'(b0.h_my_plane) + 8) % 1024;
      mv[k][fr] = (b0.v_my_plane < 16) ? 0 : int'(b0.v_my_plane) - 16;
      mcd[k] = cdp;
    end else if (b0.tick && mcd[k] > 0) mcd[k]--;
    mack[k] = alloc;
    mfp[k] = b0.fire;
  endtask
  function automatic logic [9:0] hb(int k, int i);
    return (k == 0) ? b0.h_bullet[10*i+:10] : b1.h_bullet[10*i+:10];
  endfunction
  function automatic logic [9:0] vb(int k, int i);
    return (k == 0) ? b0.v_bullet[10*i+:10] : b1.v_bullet[10*i+:10];
  endfunction
  task automatic check_model(int k);
    logic [4:0] ea;
    logic [49:0] eh;
    logic [49:0] ev;
    for (int i = 0; i < 5; i++) begin
      ea[i] = ma[k][i];
      eh[10*i+:10] = 10'(mh[k][i]);
      ev[10*i+:10] = 10'(mv[k][i]);
    end
    chk($sformatf("model active k%0d", k), (k == 0) ? b0.active : b1.active, ea);
    chk($sformatf("model fire_ack k%0d", k), (k == 0) ? b0.fire_ack : b1.fire_ack, mack[k]);
    chk($sformatf("model pool_full k%0d", k), (k == 0) ? b0.pool_full : b1.pool_full, &ea);
    chk($sformatf("model h_bullet k%0d", k), (k == 0) ? b0.h_bullet : b1.h_bullet, eh);
    chk($sformatf("model v_bullet k%0d", k), (k == 0) ? b0.v_bullet : b1.v_bullet, ev);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) if (rst) model_reset(k); else model_step(k);
    for (int k = 0; k < 2; k++) check_model(k);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    b0.tick = 0;
    b0.fire = 0;
    b0.hit = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  initial begin
    int acks0;
    int acks1;
    b0.tick = 0;
    b0.fire = 0;
    b0.hit = '0;
    b0.h_my_plane = 10'd300;
    b0.v_my_plane = 10'd400;
    tbl[0] = '{1, 5'b00001, 1, 0};
    tbl[1] = '{0, 5'b00001, 0, 0};
    tbl[2] = '{1, 5'b00011, 1, 0};
    tbl[3] = '{0, 5'b00011, 0, 0};
    tbl[4] = '{1, 5'b00111, 1, 0};
    tbl[5] = '{0, 5'b00111, 0, 0};
    tbl[6] = '{1, 5'b01111, 1, 0};
    tbl[7] = '{0, 5'b01111, 0, 0};
    tbl[8] = '{1, 5'b11111, 1, 1};
    tbl[9] = '{0, 5'b11111, 0, 1};
    tbl[10] = '{1, 5'b11111, 0, 1};
    tbl[11] = '{0, 5'b11111, 0, 1};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("reset active", (k == 0) ? b0.active : b1.active, 0);
      chk("reset fire_ack", (k == 0) ? b0.fire_ack : b1.fire_ack, 0);
      chk("reset pool_full", (k == 0) ? b0.pool_full : b1.pool_full, 0);
      for (int i = 0; i < 5; i++) begin
        chk("reset h", hb(k, i), 0);
        chk("reset v", vb(k, i), 480);
      end
    end
    acks0 = 0;
    acks1 = 0;
    b0.fire = 1;
    for (int c = 0; c < 50; c++) begin
      b0.tick = (c == 10 || c == 20 || c == 30);
      cyc();
      acks0 += int'(b0.fire_ack);
      acks1 += int'(b1.fire_ack);
      if (c == 0) begin
        chk("single fire_ack", b0.fire_ack, 1);
        chk("single h0", hb(0, 0), 308);
        chk("single v0", vb(0, 0), 384);
      end
    end
    b0.tick = 0;
    b0.fire = 0;
    chk("single v0 after 3 ticks", vb(0, 0), 378);
    chk("single ack count k0", acks0, 1);
    chk("single ack count k1", acks1, 1);
    do_reset();
    for (int r = 0; r < 12; r++) begin
      b0.fire = tbl[r].fire;
      cyc();
      chk($sformatf("exhaust active row%0d", r), b1.active, tbl[r].exp_act);
      chk($sformatf("exhaust ack row%0d", r), b1.fire_ack, tbl[r].exp_ack);
      chk($sformatf("exhaust full row%0d", r), b1.pool_full, tbl[r].exp_full);
    end
    b0.fire = 0;
    do_reset();
    b0.fire = 1;
    cyc();
    chk("cooldown first ack", b0.fire_ack, 1);
    b0.fire = 0;
    cyc();
    repeat (5) begin
      b0.tick = 1;
      cyc();
      b0.tick = 0;
      cyc();
    end
    b0.fire = 1;
    cyc();
    chk("cooldown refused ack", b0.fire_ack, 0);
    chk("cooldown refused active", b0.active, 5'b00001);
    b0.fire = 0;
    cyc();
    repeat (15) begin
      b0.tick = 1;
      cyc();
      b0.tick = 0;
      cyc();
    end
    b0.fire = 1;
    cyc();
    chk("cooldown expired ack", b0.fire_ack, 1);
    chk("cooldown expired active", b0.active, 5'b00011);
    b0.fire = 0;
    do_reset();
    b0.v_my_plane = 10'd10;
    b0.fire = 1;
    cyc();
    chk("sat spawn v", vb(0, 0), 0);
    chk("sat active", b0.active[0], 1);
    b0.fire = 0;
    b0.tick = 1;
    cyc();
    b0.tick = 0;
    chk("top exit active", b0.active[0], 0);
    chk("top exit v", vb(0, 0), 480);
    chk("top exit h", hb(0, 0), 0);
    b0.v_my_plane = 10'd400;
    do_reset();
    repeat (3) begin
      b0.fire = 1;
      cyc();
      b0.fire = 0;
      cyc();
    end
    chk("hit pre active", b1.active, 5'b00111);
    b0.fire = 1;
    b0.tick = 1;
    b0.hit = 5'b00010;
    cyc();
    chk("hit active", b1.active, 5'b01101);
    chk("hit ack", b1.fire_ack, 1);
    chk("hit v0", vb(1, 0), 382);
    chk("hit v1", vb(1, 1), 480);
    chk("hit h1", hb(1, 1), 0);
    chk("hit v2", vb(1, 2), 382);
    chk("hit v3", vb(1, 3), 384);
    b0.fire = 0;
    b0.tick = 0;
    b0.hit = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      b0.tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) b0.fire = ~b0.fire;
      for (int i = 0; i < 5; i++) b0.hit[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        b0.h_my_plane = 10'($urandom_range(0, 1023));
        b0.v_my_plane = 10'($urandom_range(0, 479));
      end
      cyc();
    end
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
